// File: rtl/bcd_cnt_ctrl.sv
// bcd_cnt_ctrl -- run controller for a chain of BCD decade counter digits.
//
// A prescaler divides clk by DIV to produce the count tick while running.
// The tick increments digit 0 and ripples carry through the chain in the
// same cycle. The count stops at a latched BCD target (DONE) or, when the
// target is zero or never matchable, free-runs with a one-cycle ovf pulse
// on the all-9s to all-0s wrap.
//
// Optional build macro: LAP_CAPTURE_EN enables the lap capture register.
// Without it the lap input is ignored and lap_out/lap_valid stay 0.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      start/resume command (level, sampled every clk)
//   stop       pause command
//   clear      synchronous clear, highest priority
//   target     BCD stop value, all-zero selects free-run
//   bcd_out    current count, digit i at [4i+3:4i]
//   state      00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
//   busy       high while state is RUN
//   done       one-cycle pulse when the target is reached
//   ovf        one-cycle pulse on wrap to all zeros
//   lap        lap capture strobe
//   lap_out    captured count
//   lap_valid  one-cycle pulse on capture
//
// state | meaning
// IDLE  | cleared, waiting for start
// RUN   | prescaler running, count advances on each tick
// PAUSE | count and prescaler phase frozen
// DONE  | count equals latched target and holds
module bcd_cnt_ctrl #(
  parameter int DIGITS = 4,
  parameter int DIV    = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic [4*DIGITS-1:0]   target,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [1:0]            state,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   lap_out,
  output logic                  lap_valid
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t        state_q, state_nxt;
  logic [W-1:0]  cnt_q, cnt_nxt, cnt_inc;
  logic [W-1:0]  tgt_q, tgt_nxt;
  logic [PW-1:0] presc_q, presc_nxt;
  logic          tick, wrap, hit;
  logic          done_nxt, ovf_nxt;

  assign tick = (state_q == RUN) && (presc_q == PRESC_MAX);

  // Same-cycle carry chain: a digit advances only when every lower digit is 9.
  always_comb begin
    logic c;
    cnt_inc = cnt_q;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) cnt_inc[4*i +: 4] = (cnt_q[4*i +: 4] >= 4'd9) ? 4'd0 : cnt_q[4*i +: 4] + 4'd1;
      c = c && (cnt_q[4*i +: 4] >= 4'd9);
    end
    wrap = c;
  end

  // A target holding a non-BCD digit can never equal cnt_inc, so it free-runs.
  assign hit = (tgt_q != '0) && (cnt_inc == tgt_q);

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    presc_nxt = presc_q;
    tgt_nxt   = tgt_q;
    done_nxt  = 1'b0;
    ovf_nxt   = 1'b0;
    if (clear) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      presc_nxt = '0;
      tgt_nxt   = '0;
    end else begin
      case (state_q)
        IDLE: if (!stop && start) begin
          state_nxt = RUN;
          tgt_nxt   = target;
          presc_nxt = '0;
        end
        RUN: begin
          presc_nxt = tick ? '0 : presc_q + PW'(1);
          if (stop) state_nxt = PAUSE;
          // A tick coinciding with stop is still applied before pausing.
          if (tick) begin
            cnt_nxt = cnt_inc;
            if (hit) begin
              state_nxt = DONE;
              done_nxt  = 1'b1;
            end else if (wrap) begin
              ovf_nxt = 1'b1;
            end
          end
        end
        PAUSE: if (!stop && start) state_nxt = RUN;
        DONE: if (!stop && start) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          presc_nxt = '0;
          tgt_nxt   = target;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      presc_q <= '0;
      tgt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      presc_q <= presc_nxt;
      tgt_q   <= tgt_nxt;
      busy    <= (state_nxt == RUN);
      done    <= done_nxt;
      ovf     <= ovf_nxt;
    end
  end

  assign bcd_out = cnt_q;
  assign state   = state_q;

`ifdef LAP_CAPTURE_EN
  // Captures the registered count, i.e. the pre-increment value on a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_out   <= '0;
      lap_valid <= 1'b0;
    end else if (clear) begin
      lap_out   <= '0;
      lap_valid <= 1'b0;
    end else if (lap && (state_q == RUN || state_q == PAUSE)) begin
      lap_out   <= cnt_q;
      lap_valid <= 1'b1;
    end else begin
      lap_valid <= 1'b0;
    end
  end
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_out    = '0;
  assign lap_valid  = 1'b0;
`endif

endmodule
